// File: rtl/freqmeas.sv
// rtl/freqmeas.sv - period and high-time meter for a slow periodic input, in clk cycles
// Define FREQMEAS_SYNC_EN to put a two-flop synchronizer in front of the edge detector.
module freqmeas #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_sig_in,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high_time,
    output logic             o_valid,
    output logic             o_timeout
);
    localparam logic [WIDTH-1:0] CMAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sig_s;
    logic             r_sig_d;
    logic             w_rise;
    logic             w_fall;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi_cap;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_time;
    logic             r_valid;
    logic             r_timeout;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_hi_cap_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic [WIDTH-1:0] w_high_time_nxt;
    logic             w_valid_nxt;
    logic             w_timeout_nxt;

`ifdef FREQMEAS_SYNC_EN
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync  <= 1'b0;
            r_sig_s <= 1'b0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= i_sig_in;
            r_sig_s <= r_sync;
            r_sig_d <= r_sig_s;
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sig_s <= 1'b0;
            r_sig_d <= 1'b0;
        end else begin
            r_sig_s <= i_sig_in;
            r_sig_d <= r_sig_s;
        end
    end
`endif

    assign w_rise = r_sig_s & ~r_sig_d;
    assign w_fall = ~r_sig_s & r_sig_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hi_cap    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hi_cap    <= w_hi_cap_nxt;
            r_period    <= w_period_nxt;
            r_high_time <= w_high_time_nxt;
            r_valid     <= w_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_hi_cap_nxt    = r_hi_cap;
        w_period_nxt    = r_period;
        w_high_time_nxt = r_high_time;
        w_valid_nxt     = 1'b0;
        w_timeout_nxt   = r_timeout;
        if (!i_enable) begin
            // results and the sticky timeout survive a disable; only the run is abandoned
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ARM;
                end
                S_ARM: begin
                    if (w_rise) begin
                        w_cnt_nxt    = ONE;
                        w_hi_cap_nxt = '0;
                        w_state_nxt  = S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (w_rise) begin
                        w_period_nxt    = r_cnt;
                        w_high_time_nxt = r_hi_cap;
                        w_valid_nxt     = 1'b1;
                        w_timeout_nxt   = 1'b0;
                        w_cnt_nxt       = ONE;
                        w_hi_cap_nxt    = '0;
                    end else if (r_cnt == CMAX) begin
                        // saturated: drop back and wait for a fresh rising edge
                        w_timeout_nxt = 1'b1;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_ARM;
                    end else begin
                        if (w_fall) begin
                            w_hi_cap_nxt = r_cnt;
                        end
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_period    = r_period;
    assign o_high_time = r_high_time;
    assign o_valid     = r_valid;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_freqmeas.sv
// tb/tb_freqmeas.sv - self-checking bench for freqmeas, WIDTH 16 and WIDTH 8 instances side by side
module tb_freqmeas;
`ifdef FREQMEAS_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sig_in = 1'b0;
    logic [15:0] per16;
    logic [15:0] hi16;
    logic        val16;
    logic        to16;
    logic [7:0]  per8;
    logic [7:0]  hi8;
    logic        val8;
    logic        to8;

    always #5 clk = ~clk;

    freqmeas #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_sig_in(sig_in),
        .o_period(per16), .o_high_time(hi16), .o_valid(val16), .o_timeout(to16)
    );

    freqmeas #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_sig_in(sig_in),
        .o_period(per8), .o_high_time(hi8), .o_valid(val8), .o_timeout(to8)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    always @(posedge clk) ecnt++;

    // Model: timestamps of the last rise/fall of the sampled signal; results are differences.
    int cmax [2] = '{65535, 255};
    int m_mode [2];
    int m_trise [2];
    int m_tfall [2];
    bit m_fell [2];
    int m_per [2];
    int m_hi [2];
    bit m_val [2];
    bit m_to [2];
    bit ss_cur, ss_prev, ss_stage, m_rise, m_fall;
    int k = 0;

    always @(posedge clk or posedge rst) begin
        k++;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_mode[d] = 0; m_trise[d] = 0; m_tfall[d] = 0; m_fell[d] = 0;
                m_per[d] = 0; m_hi[d] = 0; m_val[d] = 0; m_to[d] = 0;
            end
            ss_cur = 0; ss_prev = 0; ss_stage = 0;
        end else begin
            m_rise = ss_cur & ~ss_prev;
            m_fall = ~ss_cur & ss_prev;
            for (int d = 0; d < 2; d++) begin
                m_val[d] = 0;
                if (!enable) begin
                    m_mode[d] = 0;
                end else if (m_mode[d] == 0) begin
                    m_mode[d] = 1;
                end else if (m_mode[d] == 1) begin
                    if (m_rise) begin
                        m_mode[d] = 2; m_trise[d] = k; m_fell[d] = 0;
                    end
                end else begin
                    if (m_rise) begin
                        m_per[d] = k - m_trise[d];
                        m_hi[d]  = m_fell[d] ? (m_tfall[d] - m_trise[d]) : 0;
                        m_val[d] = 1; m_to[d] = 0; m_trise[d] = k; m_fell[d] = 0;
                    end else if (k - m_trise[d] == cmax[d]) begin
                        m_to[d] = 1; m_mode[d] = 1;
                    end else if (m_fall) begin
                        m_fell[d] = 1; m_tfall[d] = k;
                    end
                end
            end
            ss_prev = ss_cur;
`ifdef FREQMEAS_SYNC_EN
            ss_cur   = ss_stage;
            ss_stage = sig_in;
`else
            ss_cur = sig_in;
`endif
        end
    end

    int v_edge16 [$];
    int v_per16 [$];
    int v_hi16 [$];
    int v_last8 = 0;
    int to_edge8 = 0;
    bit prev_to8 = 0;

    always @(posedge clk) begin
        #1;
        chk("valid16", int'(val16), int'(m_val[0]));
        chk("period16", int'(per16), m_per[0]);
        chk("high16", int'(hi16), m_hi[0]);
        chk("timeout16", int'(to16), int'(m_to[0]));
        chk("valid8", int'(val8), int'(m_val[1]));
        chk("period8", int'(per8), m_per[1]);
        chk("high8", int'(hi8), m_hi[1]);
        chk("timeout8", int'(to8), int'(m_to[1]));
        if (val16) begin
            v_edge16.push_back(ecnt);
            v_per16.push_back(int'(per16));
            v_hi16.push_back(int'(hi16));
        end
        if (val8) v_last8 = ecnt;
        if (to8 && !prev_to8) to_edge8 = ecnt;
        prev_to8 = to8;
    end

    task automatic step(input logic s);
        @(negedge clk);
        sig_in = s;
    endtask

    task automatic wave(input int per, input int hi, input int nper);
        for (int p = 0; p < nper; p++)
            for (int i = 0; i < per; i++)
                step(i < hi);
    endtask

    task automatic settle();
        repeat (3) step(1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_per16"}, int'(per16), 0);
        chk({tag, "_hi16"}, int'(hi16), 0);
        chk({tag, "_val16"}, int'(val16), 0);
        chk({tag, "_to16"}, int'(to16), 0);
        chk({tag, "_per8"}, int'(per8), 0);
        chk({tag, "_hi8"}, int'(hi8), 0);
        chk({tag, "_val8"}, int'(val8), 0);
        chk({tag, "_to8"}, int'(to8), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    int t2;
    int n0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        step(1'b0);
        step(1'b0);

        // period 4, high 2: first rise only arms
        wave(4, 2, 1);
        step(1'b1);
        t2 = ecnt + 1;
        step(1'b1); step(1'b0); step(1'b0);
        wave(4, 2, 4);
        settle();
        chk("s1_nvalid", v_edge16.size(), 5);
        chk("s1_first_latency", v_edge16[0] - t2, 1 + SYNC);
        for (int i = 0; i < v_edge16.size(); i++) begin
            chk("s1_period", v_per16[i], 4);
            chk("s1_high", v_hi16[i], 2);
            if (i > 0) chk("s1_spacing", v_edge16[i] - v_edge16[i-1], 4);
        end

        // divide-by-3 at both duties, then toggle every cycle
        wave(3, 1, 5); settle();
        chk("s2_div3a_period", v_per16[$], 3);
        chk("s2_div3a_high", v_hi16[$], 1);
        wave(3, 2, 5); settle();
        chk("s2_div3b_period", v_per16[$], 3);
        chk("s2_div3b_high", v_hi16[$], 2);
        wave(2, 1, 6); settle();
        chk("s2_toggle_period", v_per16[$], 2);
        chk("s2_toggle_high", v_hi16[$], 1);

        // one rise then stuck low: the 8-bit instance saturates
        step(1'b1);
        repeat (300) step(1'b0);
        chk("s3_to8_set", int'(to8), 1);
        chk("s3_to8_latency", to_edge8 - v_last8, 255);
        chk("s3_per8_hold", int'(per8), 5);
        chk("s3_hi8_hold", int'(hi8), 1);
        chk("s3_to16_clear", int'(to16), 0);
        wave(6, 3, 1);
        chk("s3_to8_after_first_rise", int'(to8), 1);
        wave(6, 3, 2); settle();
        chk("s3_to8_cleared", int'(to8), 0);
        chk("s3_per8_resumed", int'(per8), 6);
        chk("s3_hi8_resumed", int'(hi8), 3);

        // enable dropped two cycles into a period-10 wave, back five cycles later
        wave(10, 5, 3);
        step(1'b1); step(1'b1);
        n0 = v_edge16.size();
        enable = 1'b0;
        step(1'b1); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        enable = 1'b1;
        step(1'b0); step(1'b0); step(1'b0);
        chk("s4_gap_nvalid", v_edge16.size() - n0, 0);
        chk("s4_gap_per16_hold", int'(per16), 10);
        chk("s4_gap_hi16_hold", int'(hi16), 5);
        n0 = v_edge16.size();
        wave(10, 5, 1);
        chk("s4_rearm_nvalid", v_edge16.size() - n0, 0);
        wave(10, 5, 1); settle();
        chk("s4_after_nvalid", v_edge16.size() - n0, 1);
        chk("s4_period", v_per16[$], 10);
        chk("s4_high", v_hi16[$], 5);

        // asynchronous reset in the middle of a measurement
        wave(8, 4, 2);
        step(1'b1); step(1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("s5_reset");
        n0 = v_edge16.size();
        step(1'b0); step(1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        step(1'b0); step(1'b0);
        wave(8, 4, 1);
        chk("s5_first_period_nvalid", v_edge16.size() - n0, 0);
        wave(8, 4, 1); settle();
        chk("s5_second_period_nvalid", v_edge16.size() - n0, 1);
        chk("s5_period", v_per16[$], 8);
        chk("s5_high", v_hi16[$], 4);

        // duty sweep at period 8
        for (int h = 1; h < 8; h++) begin
            wave(8, h, 3); settle();
            chk("s6_period16", int'(per16), 8);
            chk("s6_high16", int'(hi16), h);
            chk("s6_period8", int'(per8), 8);
            chk("s6_high8", int'(hi8), h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
